// File: rtl/mem_wb_pipe_pkg.sv
// Shared widths and ROB age helpers for the MEM->WB pipeline, ROB and issue queue.
package mem_wb_pipe_pkg;

    localparam int unsigned LanesDef  = 2;
    localparam int unsigned DataWDef  = 32;
    localparam int unsigned PregWDef  = 6;
    localparam int unsigned RobWDef   = 5;
    localparam int unsigned RobTagMax = 16;

    // Age is distance from rob_head, modulo the ROB depth; larger age means younger.
    function automatic logic rob_younger(input logic [RobTagMax-1:0] tag,
                                         input logic [RobTagMax-1:0] ref_tag,
                                         input logic [RobTagMax-1:0] head,
                                         input int unsigned          rob_w);
        logic [RobTagMax-1:0] mask;
        logic [RobTagMax-1:0] age_tag;
        logic [RobTagMax-1:0] age_ref;
        mask    = {RobTagMax{1'b1}} >> (RobTagMax - rob_w);
        age_tag = (tag - head) & mask;
        age_ref = (ref_tag - head) & mask;
        return age_tag > age_ref;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// Handshake, payload and kill-control bundle between completion stage and writeback.
interface mem_wb_pipe_if
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned LANES  = LanesDef,
    parameter int unsigned DATA_W = DataWDef,
    parameter int unsigned PREG_W = PregWDef,
    parameter int unsigned ROB_W  = RobWDef
);
    logic [LANES-1:0]        in_valid;
    logic [LANES-1:0]        in_ready;
    logic [LANES-1:0]        in_wen;
    logic [LANES*PREG_W-1:0] in_preg;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES*ROB_W-1:0]  in_rob;

    logic [LANES-1:0]        out_valid;
    logic [LANES-1:0]        out_ready;
    logic [LANES-1:0]        out_wen;
    logic [LANES*PREG_W-1:0] out_preg;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES*ROB_W-1:0]  out_rob;

    logic                    flush;
    logic                    squash_valid;
    logic [ROB_W-1:0]        squash_rob;
    logic [ROB_W-1:0]        rob_head;

    modport master (
        output in_valid, in_wen, in_preg, in_data, in_rob, out_ready,
        output flush, squash_valid, squash_rob, rob_head,
        input  in_ready, out_valid, out_wen, out_preg, out_data, out_rob
    );

    modport slave (
        input  in_valid, in_wen, in_preg, in_data, in_rob, out_ready,
        input  flush, squash_valid, squash_rob, rob_head,
        output in_ready, out_valid, out_wen, out_preg, out_data, out_rob
    );
endinterface

// File: rtl/mem_wb_pipe_wb_skid_lane.sv
// Single-lane 2-entry skid register; kill inputs clear the valid of the matching entry.
module wb_skid_lane #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload,
    output logic [W-1:0] skid_payload,
    input  logic         kill_main,
    input  logic         kill_skid,
    input  logic         kill_in
);
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_xfer;

    assign in_ready     = ~skid_valid_q;
    assign out_valid    = main_valid_q;
    assign out_payload  = main_q;
    assign skid_payload = skid_q;
    assign in_xfer      = in_valid & ~skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (out_ready || !main_valid_q) begin
            // An entry leaving main this cycle counts as written back even if killed.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = ~kill_skid;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_d       = in_payload;
                main_valid_d = ~kill_in;
            end else begin
                main_valid_d = 1'b0;
            end
        end else begin
            main_valid_d = ~kill_main;
            if (in_xfer) begin
                skid_d       = in_payload;
                skid_valid_d = ~kill_in;
            end else begin
                skid_valid_d = skid_valid_q & ~kill_skid;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// Multi-lane MEM->WB pipeline register with flush and tag-based squash of younger entries.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned LANES  = LanesDef,
    parameter int unsigned DATA_W = DataWDef,
    parameter int unsigned PREG_W = PregWDef,
    parameter int unsigned ROB_W  = RobWDef
) (
    input logic           clk,
    input logic           rstn,
    mem_wb_pipe_if.slave  bus
);
    localparam int unsigned PW = 1 + PREG_W + DATA_W + ROB_W;

    logic [RobTagMax-1:0] sq_tag;
    logic [RobTagMax-1:0] head_tag;

    assign sq_tag   = RobTagMax'(bus.squash_rob);
    assign head_tag = RobTagMax'(bus.rob_head);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PW-1:0] in_pl;
        logic [PW-1:0] main_pl;
        logic [PW-1:0] skid_pl;
        logic          kill_main;
        logic          kill_skid;
        logic          kill_in;

        // Payload layout: {wen, preg, data, rob}; rob sits in the low bits.
        assign in_pl = {bus.in_wen[i], bus.in_preg[i*PREG_W +: PREG_W],
                        bus.in_data[i*DATA_W +: DATA_W], bus.in_rob[i*ROB_W +: ROB_W]};

        assign kill_main = bus.flush | (bus.squash_valid &
            rob_younger(RobTagMax'(main_pl[ROB_W-1:0]), sq_tag, head_tag, ROB_W));
        assign kill_skid = bus.flush | (bus.squash_valid &
            rob_younger(RobTagMax'(skid_pl[ROB_W-1:0]), sq_tag, head_tag, ROB_W));
        assign kill_in   = bus.flush | (bus.squash_valid &
            rob_younger(RobTagMax'(in_pl[ROB_W-1:0]), sq_tag, head_tag, ROB_W));

        wb_skid_lane #(
            .W (PW)
        ) u_lane (
            .clk          (clk),
            .rstn         (rstn),
            .in_valid     (bus.in_valid[i]),
            .in_ready     (bus.in_ready[i]),
            .in_payload   (in_pl),
            .out_valid    (bus.out_valid[i]),
            .out_ready    (bus.out_ready[i]),
            .out_payload  (main_pl),
            .skid_payload (skid_pl),
            .kill_main    (kill_main),
            .kill_skid    (kill_skid),
            .kill_in      (kill_in)
        );

        assign bus.out_wen[i]                    = main_pl[PW-1];
        assign bus.out_preg[i*PREG_W +: PREG_W]  = main_pl[PW-2 -: PREG_W];
        assign bus.out_data[i*DATA_W +: DATA_W]  = main_pl[ROB_W +: DATA_W];
        assign bus.out_rob[i*ROB_W +: ROB_W]     = main_pl[ROB_W-1:0];
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: reset, latency, backpressure, squash, flush, async reset.
module tb_mem_wb_pipe;
    logic clk;
    logic rstn;
    int   passed;
    int   total;

    mem_wb_pipe_if #(.LANES(2), .DATA_W(32), .PREG_W(6), .ROB_W(5)) bus ();

    mem_wb_pipe #(
        .LANES  (2),
        .DATA_W (32),
        .PREG_W (6),
        .ROB_W  (5)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic v, input logic [5:0] preg,
                            input logic [31:0] data, input logic [4:0] rob);
        bus.in_valid[l]         = v;
        bus.in_wen[l]           = 1'b1;
        bus.in_preg[l*6 +: 6]   = preg;
        bus.in_data[l*32 +: 32] = data;
        bus.in_rob[l*5 +: 5]    = rob;
    endtask

    // Two pushes per lane with out_ready low: main then skid fill.
    task automatic fill_both(input logic [4:0] r0a, input logic [4:0] r0b,
                             input logic [4:0] r1a, input logic [4:0] r1b);
        bus.out_ready = 2'b00;
        set_lane(0, 1'b1, 6'd1, 32'hA0, r0a);
        set_lane(1, 1'b1, 6'd2, 32'hB0, r1a);
        tick();
        set_lane(0, 1'b1, 6'd3, 32'hA1, r0b);
        set_lane(1, 1'b1, 6'd4, 32'hB1, r1b);
        tick();
        bus.in_valid = 2'b00;
    endtask

    task automatic test_reset();
        #12;
        total++; if (bus.out_valid !== 2'b00) $display("FAIL reset_out_valid: got %b want 00", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL reset_in_ready: got %b want 11", bus.in_ready); else passed++;
        total++; if (bus.out_data !== 64'd0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else passed++;
        total++; if (bus.out_preg !== 12'd0) $display("FAIL reset_out_preg: got %h want 0", bus.out_preg); else passed++;
        total++; if (bus.out_rob !== 10'd0) $display("FAIL reset_out_rob: got %h want 0", bus.out_rob); else passed++;
        total++; if (bus.out_wen !== 2'b00) $display("FAIL reset_out_wen: got %b want 00", bus.out_wen); else passed++;
        #5 rstn = 1'b1;
    endtask

    task automatic test_basic();
        bus.out_ready = 2'b11;
        set_lane(0, 1'b1, 6'd5, 32'hDEADBEEF, 5'd3);
        tick();
        bus.in_valid = 2'b00;
        total++; if (bus.out_valid !== 2'b01) $display("FAIL basic_valid: got %b want 01", bus.out_valid); else passed++;
        total++; if (bus.out_preg[5:0] !== 6'd5) $display("FAIL basic_preg: got %0d want 5", bus.out_preg[5:0]); else passed++;
        total++; if (bus.out_data[31:0] !== 32'hDEADBEEF) $display("FAIL basic_data: got %h want deadbeef", bus.out_data[31:0]); else passed++;
        total++; if (bus.out_rob[4:0] !== 5'd3) $display("FAIL basic_rob: got %0d want 3", bus.out_rob[4:0]); else passed++;
        total++; if (bus.out_wen[0] !== 1'b1) $display("FAIL basic_wen: got %b want 1", bus.out_wen[0]); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL basic_in_ready: got %b want 11", bus.in_ready); else passed++;
        tick();
        total++; if (bus.out_valid !== 2'b00) $display("FAIL basic_drain: got %b want 00", bus.out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_rob;
        bus.out_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            exp_rob = 5'(4 + k);
            set_lane(1, 1'b1, 6'd9, 32'h100 + 32'(k), exp_rob);
            tick();
            total++; if (bus.out_valid[1] !== 1'b1 || bus.out_rob[9:5] !== exp_rob)
                $display("FAIL b2b_rob%0d: got v=%b rob=%0d want v=1 rob=%0d", k, bus.out_valid[1], bus.out_rob[9:5], exp_rob);
            else passed++;
            total++; if (bus.in_ready !== 2'b11) $display("FAIL b2b_ready%0d: got %b want 11", k, bus.in_ready); else passed++;
        end
        bus.in_valid = 2'b00;
        tick();
        total++; if (bus.out_valid !== 2'b00) $display("FAIL b2b_drain: got %b want 00", bus.out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 2'b00;
        set_lane(0, 1'b1, 6'd7, 32'h11, 5'd1);
        tick();
        total++; if (bus.out_valid[0] !== 1'b1 || bus.out_rob[4:0] !== 5'd1)
            $display("FAIL bp_first: got v=%b rob=%0d want v=1 rob=1", bus.out_valid[0], bus.out_rob[4:0]);
        else passed++;
        total++; if (bus.in_ready[0] !== 1'b1) $display("FAIL bp_ready1: got %b want 1", bus.in_ready[0]); else passed++;
        set_lane(0, 1'b1, 6'd8, 32'h22, 5'd2);
        tick();
        bus.in_valid = 2'b00;
        total++; if (bus.in_ready[0] !== 1'b0) $display("FAIL bp_ready_drop: got %b want 0", bus.in_ready[0]); else passed++;
        total++; if (bus.out_rob[4:0] !== 5'd1) $display("FAIL bp_held: got %0d want 1", bus.out_rob[4:0]); else passed++;
        bus.out_ready = 2'b11;
        tick();
        total++; if (bus.out_valid[0] !== 1'b1 || bus.out_rob[4:0] !== 5'd2)
            $display("FAIL bp_second: got v=%b rob=%0d want v=1 rob=2", bus.out_valid[0], bus.out_rob[4:0]);
        else passed++;
        total++; if (bus.out_data[31:0] !== 32'h22) $display("FAIL bp_data: got %h want 22", bus.out_data[31:0]); else passed++;
        total++; if (bus.in_ready[0] !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", bus.in_ready[0]); else passed++;
        tick();
        total++; if (bus.out_valid !== 2'b00) $display("FAIL bp_drain: got %b want 00", bus.out_valid); else passed++;
    endtask

    task automatic test_squash();
        // head=30, ref=0 (age 2): 31 (age 1) and 0 (equal) survive; 1 (age 3) and 5 (age 7) die.
        bus.rob_head  = 5'd30;
        bus.out_ready = 2'b00;
        set_lane(0, 1'b1, 6'd10, 32'h31, 5'd31);
        set_lane(1, 1'b1, 6'd11, 32'h40, 5'd0);
        tick();
        set_lane(0, 1'b1, 6'd12, 32'h01, 5'd1);
        bus.in_valid[1] = 1'b0;
        tick();
        total++; if (bus.in_ready !== 2'b10) $display("FAIL sq_setup_ready: got %b want 10", bus.in_ready); else passed++;
        bus.in_valid[0]  = 1'b0;
        set_lane(1, 1'b1, 6'd13, 32'h55, 5'd5);
        bus.squash_valid = 1'b1;
        bus.squash_rob   = 5'd0;
        tick();
        bus.squash_valid = 1'b0;
        bus.in_valid     = 2'b00;
        total++; if (bus.out_valid !== 2'b11) $display("FAIL sq_valid: got %b want 11", bus.out_valid); else passed++;
        total++; if (bus.out_rob[4:0] !== 5'd31) $display("FAIL sq_lane0_rob: got %0d want 31", bus.out_rob[4:0]); else passed++;
        total++; if (bus.out_rob[9:5] !== 5'd0) $display("FAIL sq_lane1_rob: got %0d want 0", bus.out_rob[9:5]); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL sq_ready: got %b want 11", bus.in_ready); else passed++;
        bus.out_ready = 2'b11;
        tick();
        total++; if (bus.out_valid !== 2'b00) $display("FAIL sq_killed: got %b want 00", bus.out_valid); else passed++;
        bus.rob_head = 5'd0;
    endtask

    task automatic test_flush();
        fill_both(5'd10, 5'd11, 5'd12, 5'd13);
        total++; if (bus.in_ready !== 2'b00) $display("FAIL fl_full: got %b want 00", bus.in_ready); else passed++;
        set_lane(0, 1'b1, 6'd20, 32'hC0, 5'd14);
        set_lane(1, 1'b1, 6'd21, 32'hC1, 5'd15);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 2'b00;
        total++; if (bus.out_valid !== 2'b00) $display("FAIL fl_valid: got %b want 00", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL fl_ready: got %b want 11", bus.in_ready); else passed++;
        // Main held, input accepted into skid on the flush edge must be dropped.
        set_lane(0, 1'b1, 6'd22, 32'hD0, 5'd16);
        set_lane(1, 1'b1, 6'd23, 32'hD1, 5'd17);
        tick();
        set_lane(0, 1'b1, 6'd24, 32'hD2, 5'd18);
        set_lane(1, 1'b1, 6'd25, 32'hD3, 5'd19);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 2'b00;
        total++; if (bus.out_valid !== 2'b00) $display("FAIL fl_in_valid: got %b want 00", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL fl_in_ready: got %b want 11", bus.in_ready); else passed++;
        bus.out_ready = 2'b11;
        tick();
        total++; if (bus.out_valid !== 2'b00) $display("FAIL fl_dropped: got %b want 00", bus.out_valid); else passed++;
    endtask

    task automatic test_flush_squash();
        // head=0, ref=31: nothing is younger, so squash alone kills nothing.
        fill_both(5'd1, 5'd2, 5'd3, 5'd4);
        bus.squash_valid = 1'b1;
        bus.squash_rob   = 5'd31;
        tick();
        bus.squash_valid = 1'b0;
        total++; if (bus.out_valid !== 2'b11) $display("FAIL sqonly_valid: got %b want 11", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 2'b00) $display("FAIL sqonly_ready: got %b want 00", bus.in_ready); else passed++;
        bus.out_ready = 2'b11;
        tick();
        total++; if (bus.out_rob !== {5'd4, 5'd2}) $display("FAIL sqonly_skid: got %h want %h", bus.out_rob, {5'd4, 5'd2}); else passed++;
        tick();
        fill_both(5'd1, 5'd2, 5'd3, 5'd4);
        bus.squash_valid = 1'b1;
        bus.squash_rob   = 5'd31;
        bus.flush        = 1'b1;
        tick();
        bus.squash_valid = 1'b0;
        bus.flush        = 1'b0;
        total++; if (bus.out_valid !== 2'b00) $display("FAIL flsq_valid: got %b want 00", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL flsq_ready: got %b want 11", bus.in_ready); else passed++;
    endtask

    task automatic test_async_reset();
        fill_both(5'd6, 5'd7, 5'd8, 5'd9);
        #2 rstn = 1'b0;
        #1;
        total++; if (bus.out_valid !== 2'b00) $display("FAIL ar_valid: got %b want 00", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL ar_ready: got %b want 11", bus.in_ready); else passed++;
        total++; if (bus.out_data !== 64'd0) $display("FAIL ar_data: got %h want 0", bus.out_data); else passed++;
        #2 rstn = 1'b1;
        bus.out_ready = 2'b11;
        tick();
        total++; if (bus.out_valid !== 2'b00) $display("FAIL ar_after: got %b want 00", bus.out_valid); else passed++;
    endtask

    initial begin
        passed           = 0;
        total            = 0;
        rstn             = 1'b0;
        bus.in_valid     = '0;
        bus.in_wen       = '0;
        bus.in_preg      = '0;
        bus.in_data      = '0;
        bus.in_rob       = '0;
        bus.out_ready    = '0;
        bus.flush        = 1'b0;
        bus.squash_valid = 1'b0;
        bus.squash_rob   = '0;
        bus.rob_head     = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_squash();
        test_flush();
        test_flush_squash();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised, multi-lane MEM→WB pipeline register for the out-of-order core. Each lane carries one completed micro-op result (physical destination, data, ROB tag) from the memory/execute completion stage to the writeback/CDB stage. It uses a 2-entry skid buffer per lane, so the valid/ready handshake is fully registered on both sides. It supports a global flush and a tag-based squash of younger instructions on branch mispredict.

## Interface
Parameters:
- LANES, 2, number of independent writeback lanes
- DATA_W, 32, result data width
- PREG_W, 6, physical register index width
- ROB_W, 5, ROB tag width (ROB depth = 2^ROB_W)

Ports (per-lane fields flattened, lane i at bits [i*W +: W]):
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  LANES  upstream result valid
- in_ready  out  LANES  lane can accept (registered)
- in_wen  in  LANES  result writes a register
- in_preg  in  LANES*PREG_W  destination physical register
- in_data  in  LANES*DATA_W  result data
- in_rob  in  LANES*ROB_W  ROB tag
- out_valid  out  LANES  writeback entry valid
- out_ready  in  LANES  WB stage consumes entry
- out_wen, out_preg, out_data, out_rob  out  as inputs  registered fields
- flush  in  1  kill all in-flight entries
- squash_valid  in  1  kill entries younger than squash_rob
- squash_rob  in  ROB_W  tag of mispredicted branch (it survives)
- rob_head  in  ROB_W  current oldest ROB tag, for age comparison

## Operation
- Each lane has a main register (drives out_*) and a skid register; the lanes are fully independent.
- A transfer occurs on in_valid&in_ready, and on out_valid&out_ready.
- in_ready = ~skid_valid. It is a pure flop output with no combinational path from out_ready.
- Main register update, when out_ready or ~main_valid:
  - If skid_valid, load from skid and clear skid.
  - Else load from the input if it is transferring.
  - Else clear main_valid.
- Skid update: if an input transfers while main is held (main_valid & ~out_ready), the input goes to skid.
- Age rule: age(t) = (t − rob_head) mod 2^ROB_W. An entry is younger iff age(entry) > age(squash_rob).
- Squash: when squash_valid, clear the valid bit of any main, skid or incoming entry that is younger. Equal tag or older survives.
- Flush: clear all main and skid valids. The same-cycle input transfer is dropped. Flush overrides squash.
- Data fields are not cleared on flush or squash; only valids are.

## Timing
- Reset: all out_valid=0, skid_valid=0, in_ready=all 1, out_wen/out_preg/out_data/out_rob=0.
- Latency is 1 cycle from input transfer to out_valid with an empty lane and out_ready=1.
- Throughput is 1 entry per cycle per lane with out_ready held high.
- With out_ready low, a lane accepts 2 entries, then in_ready drops the following cycle.
- in_ready reasserts the cycle after the skid drains.
- Order within a lane is preserved. The skid entry is always older than any later input.
- Flush or squash takes effect at the clock edge. out_valid of killed entries is 0 the next cycle.
- An entry transferring out in the same cycle as a kill is considered written back (consumer's responsibility).
- Reset asserted mid-operation clears all state asynchronously. No output glitches to a valid=1 state during reset.

## Structure
- A shared package/header holds the default widths and an age-compare function `rob_younger(tag, ref, head)`; the ROB and issue queue reuse it.
- One sub-module is natural: `wb_skid_lane`, a single-lane 2-entry skid register with kill input. The top instantiates LANES copies with a generate loop and computes each lane's kill from flush and the squash compare.

## Test plan
- Reset, then drive lane0 in_valid=1 with preg=5, data=0xDEADBEEF, rob=3, out_ready=1 → out_valid=1 next cycle with those values; in_ready stays 1.
- Backpressure: out_ready=0, push rob=1 then rob=2 → in_ready=0 on the third cycle. Raise out_ready → rob=1 out, then rob=2; in_ready returns to 1.
- Squash: rob_head=30, lane holds main rob=31 and skid rob=1; squash_rob=0 → rob=31 kept, rob=1 killed (wrap-around age).
- Flush: both lanes hold main+skid and an input is arriving; pulse flush → all out_valid=0 next cycle, the input is dropped, in_ready=all 1.
- Simultaneous flush and squash_valid → identical result to flush alone.
- Random multi-lane streams with random out_ready, squash and flush, checked against a reference queue model for ordering, no loss or duplication, and correct kill set.
